// File: rtl/e_mdu_if.sv
// e_mdu operand/result bundle between the execute stage and the MDU.
// The execute stage drives operands (master); the MDU returns HI/LO and stall (slave).
interface e_mdu_if;
    logic        start;
    logic [2:0]  mdu_c;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_c, data1, data2,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, mdu_c, data1, data2,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding HI/LO with fixed-latency busy timing.
// Optional macro MDU_DIV0_HOLD_EN: div/divu by zero becomes a no-op.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   rst_n,
    e_mdu_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic        is_md;
    logic        is_div;
    logic        div0;
    logic        div0_hold;
    logic [63:0] md_res;
    logic [3:0]  md_cyc;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_den, u_den;
    logic [31:0] uq, ur, sq, sr, dq, dr;

    assign is_md  = (bus.mdu_c >= OP_MULT) && (bus.mdu_c <= OP_DIVU);
    assign is_div = (bus.mdu_c == OP_DIV) || (bus.mdu_c == OP_DIVU);
    assign div0   = (bus.data2 == 32'd0);

`ifdef MDU_DIV0_HOLD_EN
    assign div0_hold = is_div && div0;
`else
    assign div0_hold = 1'b0;
`endif

    assign a_sx   = {{32{bus.data1[31]}}, bus.data1};
    assign b_sx   = {{32{bus.data2[31]}}, bus.data2};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, bus.data1} * {32'd0, bus.data2};

    // Signed divide on magnitudes so -2^31 / -1 wraps to 0x80000000 cleanly
    assign a_neg = bus.data1[31];
    assign b_neg = bus.data2[31];
    assign a_mag = a_neg ? -bus.data1 : bus.data1;
    assign b_mag = b_neg ? -bus.data2 : bus.data2;
    assign b_den = div0 ? 32'd1 : b_mag;
    assign u_den = div0 ? 32'd1 : bus.data2;
    assign uq    = a_mag / b_den;
    assign ur    = a_mag % b_den;
    assign sq    = (a_neg ^ b_neg) ? -uq : uq;
    assign sr    = a_neg ? -ur : ur;
    assign dq    = bus.data1 / u_den;
    assign dr    = bus.data1 % u_den;

    always_comb begin
        md_res = 64'd0;
        md_cyc = MULT_N;
        unique case (bus.mdu_c)
            OP_MULT:  md_res = prod_s;
            OP_MULTU: md_res = prod_u;
            OP_DIV: begin
                md_cyc = DIV_N;
                md_res = div0 ? {bus.data1, 32'hFFFF_FFFF} : {sr, sq};
            end
            OP_DIVU: begin
                md_cyc = DIV_N;
                md_res = div0 ? {bus.data1, 32'hFFFF_FFFF} : {dr, dq};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_md && !div0_hold) begin
                        {pend_hi_d, pend_lo_d} = md_res;
                        cnt_d   = md_cyc;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end else if (bus.mdu_c == OP_MTHI) begin
                        hi_d = bus.data1;
                    end else if (bus.mdu_c == OP_MTLO) begin
                        lo_d = bus.data1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.stall_req = busy_q || (bus.start && is_md);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: arithmetic reference model plus directed and random stimulus.
// Honours MDU_DIV0_HOLD_EN when predicting divide-by-zero behaviour.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

`ifdef MDU_DIV0_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    e_mdu_if bus ();

    e_mdu #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: remembers the edge at which a pending result lands
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_res = 0;
    bit          m_pend = 0;
    longint      m_edge = 0, m_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= 0;
            m_lo   <= 0;
            m_res  <= 0;
            m_pend <= 0;
            m_edge <= 0;
            m_done <= 0;
        end else begin
            m_edge <= m_edge + 1;
            if (m_pend) begin
                if (m_edge + 1 == m_done) begin
                    {m_hi, m_lo} <= m_res;
                    m_pend <= 0;
                end
            end else if (bus.start) begin
                if (bus.mdu_c inside {[3'd1:3'd4]} &&
                    !(HOLD && bus.mdu_c >= 3'd3 && bus.data2 == 0)) begin
                    m_res  <= ref_calc(bus.mdu_c, bus.data1, bus.data2);
                    m_pend <= 1;
                    m_done <= m_edge + 1 + ((bus.mdu_c <= 3'd2) ? MC : DC);
                end else if (bus.mdu_c == 3'd5) begin
                    m_hi <= bus.data1;
                end else if (bus.mdu_c == 3'd6) begin
                    m_lo <= bus.data1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_pend));
        chk("stall", 32'(bus.stall_req),
            32'(m_pend || (bus.start && bus.mdu_c inside {[3'd1:3'd4]})));
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        #2;
        bus.start = 1'b1;
        bus.mdu_c = op;
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mdu_c = 3'd0;
    endtask

    task automatic wait_idle(input string nm, input int exp_n);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        chk(nm, 32'(n), 32'(exp_n));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [63:0] r64;

    initial begin
        bus.start = 1'b0;
        bus.mdu_c = 3'd0;
        bus.data1 = 32'd0;
        bus.data2 = 32'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        #1 rst_n = 1'b1;

        r64 = ref_calc(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("ref_mult", r64[31:0], 32'hFFFF_FFFA);
        r64 = ref_calc(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("ref_div_q", r64[31:0], 32'hFFFF_FFFD);
        chk("ref_div_r", r64[63:32], 32'hFFFF_FFFF);
        r64 = ref_calc(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ref_ovf", r64[31:0], 32'h8000_0000);

        @(negedge clk);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle("mult_cyc", MC);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle("multu_cyc", MC);
        chk("multu_hi", bus.hi, 32'h0000_0002);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_cyc", DC);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(3'd4, 32'd7, 32'd2);
        wait_idle("divu_cyc", DC);
        chk("divu_lo", bus.lo, 32'd3);
        chk("divu_hi", bus.hi, 32'd1);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("ovf_cyc", DC);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'd0);

        issue(3'd5, 32'h1234_5678, 32'd0);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
        chk("mtlo_hi", bus.hi, 32'h1234_5678);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);

        issue(3'd1, 32'd7, 32'd6);
        issue(3'd6, 32'hDEAD_BEEF, 32'd0);
        wait_idle("ign_cyc", MC - 1);
        chk("ign_lo", bus.lo, 32'd42);
        chk("ign_hi", bus.hi, 32'd0);

        issue(3'd3, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_hi", bus.hi, 32'd0);
        chk("mrst_lo", bus.lo, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (DC + 2) @(negedge clk);
        chk("post_hi", bus.hi, 32'd0);
        chk("post_lo", bus.lo, 32'd0);

        issue(3'd3, 32'h55, 32'd0);
`ifdef MDU_DIV0_HOLD_EN
        wait_idle("d0_cyc", 0);
        chk("d0_hi", bus.hi, 32'd0);
        chk("d0_lo", bus.lo, 32'd0);
`else
        wait_idle("d0_cyc", DC);
        chk("d0_hi", bus.hi, 32'h55);
        chk("d0_lo", bus.lo, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 3) != 0);
            bus.mdu_c = 3'($urandom_range(0, 7));
            bus.data1 = pick();
            bus.data2 = pick();
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (DC + 4) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
